hub_shift_pipe: RTL and testbench

- Pipelined, parametrised successor to the combinational mantissa shifter used in the HUB floating-point adder datapath.
- Performs left, logical-right or arithmetic-right shifts of a signed W-bit mantissa.
- Adds a sticky/overflow bit for rounding and normalisation, saturating shift amounts, and a valid/ready handshake.
- Sits between exponent-difference logic and the mantissa adder (alignment), and after leading-zero detection (normalisation).

---
 rtl/hub_shift_pkg.sv | 37 +++
 rtl/hub_shift_stage.sv | 89 ++++++++
 rtl/hub_shift_pipe.sv | 80 ++++++++
 tb/tb_hub_shift_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub_shift_pkg.sv
// Shared types, default geometry and helpers for the pipelined HUB mantissa shifter.
package hub_shift_pkg;

   localparam int unsigned M_DEF      = 23;
   localparam int unsigned E_DEF      = 8;
   localparam int unsigned X_DEF      = 7;
   localparam int unsigned STAGES_DEF = 2;

   localparam int unsigned W                = M_DEF + X_DEF;
   localparam int unsigned L                = $clog2(W);
   localparam int unsigned LEVELS_PER_STAGE = (L + STAGES_DEF - 1) / STAGES_DEF;

   typedef enum logic [1:0] {
      SH_LEFT   = 2'b00,
      SH_RLOG   = 2'b01,
      SH_RARITH = 2'b10
   } shift_mode_t;

   // Clamp a shift distance to the word width; a shift by exactly width
   // pushes every original bit out, which is the saturated result.
   function automatic int unsigned sat_shift_amount(input int unsigned amt,
                                                    input int unsigned width);
      return (amt >= width) ? width : amt;
   endfunction

   // The reserved encoding 2'b11 behaves as a logical right shift.
   function automatic shift_mode_t decode_mode(input logic [1:0] m);
      shift_mode_t r;
      case (m)
         2'b00:   r = SH_LEFT;
         2'b10:   r = SH_RARITH;
         default: r = SH_RLOG;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/hub_shift_stage.sv
// One pipeline stage: a run of power-of-two shift levels (optionally followed by
// the saturation level) and the register that closes the stage.
module hub_shift_stage
   import hub_shift_pkg::*;
#(
   parameter int unsigned WIDTH = W,
   parameter int unsigned AW    = L + 1,
   parameter int unsigned BASE  = 0,
   parameter int unsigned NLEV  = 1,
   parameter bit          SAT   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic [AW-1:0]    amt_i,
   input  shift_mode_t      mode_i,
   input  logic             sticky_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [AW-1:0]    amt_o,
   output shift_mode_t      mode_o,
   output logic             sticky_o
);

   logic [WIDTH-1:0] data_d;
   logic             sticky_d;
   logic [AW-1:0]    amt_sh;

   logic             valid_q;
   logic [WIDTH-1:0] data_q;
   logic [AW-1:0]    amt_q;
   shift_mode_t      mode_q;
   logic             sticky_q;

   // Shift through this stage's levels, collecting every bit that leaves the word.
   always_comb begin
      data_d   = data_i;
      sticky_d = sticky_i;
      amt_sh   = '0;
      for (int k = 0; k < int'(NLEV); k++) begin
         amt_sh = amt_i >> (int'(BASE) + k);
         if (amt_sh[0]) begin
            if (mode_i == SH_LEFT) begin
               sticky_d = sticky_d | (|(data_d & ~({WIDTH{1'b1}} >> (1 << (int'(BASE) + k)))));
               data_d   = data_d << (1 << (int'(BASE) + k));
            end else begin
               // Amounts are clamped to WIDTH, so only original bits ever leave here.
               sticky_d = sticky_d | (|(data_d & ~({WIDTH{1'b1}} << (1 << (int'(BASE) + k)))));
               if (mode_i == SH_RARITH) begin
                  data_d = WIDTH'($signed(data_d) >>> (1 << (int'(BASE) + k)));
               end else begin
                  data_d = data_d >> (1 << (int'(BASE) + k));
               end
            end
         end
      end
      // Saturation level: only reachable when WIDTH is a power of two.
      if (SAT && amt_i[AW-1]) begin
         sticky_d = sticky_d | (|data_d);
         data_d   = (mode_i == SH_RARITH) ? {WIDTH{data_d[WIDTH-1]}} : '0;
      end
   end

   // Stage register; moves only when the whole pipeline advances.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         amt_q    <= '0;
         mode_q   <= SH_LEFT;
         sticky_q <= 1'b0;
      end else if (adv_i) begin
         valid_q  <= valid_i;
         data_q   <= data_d;
         amt_q    <= amt_i;
         mode_q   <= mode_i;
         sticky_q <= sticky_d;
      end
   end

   assign valid_o  = valid_q;
   assign data_o   = data_q;
   assign amt_o    = amt_q;
   assign mode_o   = mode_q;
   assign sticky_o = sticky_q;

endmodule

// File: rtl/hub_shift_pipe.sv
// Pipelined left / logical-right / arithmetic-right mantissa shifter with sticky
// collection, saturating shift amounts and a valid/ready handshake.
module hub_shift_pipe
   import hub_shift_pkg::*;
#(
   parameter int unsigned M                   = M_DEF,
   parameter int unsigned E                   = E_DEF,
   parameter int unsigned extra_bits_mantissa = X_DEF,
   parameter int unsigned STAGES              = STAGES_DEF
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [M+extra_bits_mantissa-1:0]   number_input,
   input  logic [E:0]                         shift_amount,
   input  logic [1:0]                         mode,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [M+extra_bits_mantissa-1:0]   number_output,
   output logic                               sticky
);

   localparam int unsigned WIDTH = M + extra_bits_mantissa;
   localparam int unsigned LVL   = $clog2(WIDTH);
   localparam int unsigned AW    = LVL + 1;
   localparam int unsigned LPS   = (LVL + STAGES - 1) / STAGES;

   logic             adv;
   logic             valid_w  [STAGES+1];
   logic [WIDTH-1:0] data_w   [STAGES+1];
   logic [AW-1:0]    amt_w    [STAGES+1];
   shift_mode_t      mode_w   [STAGES+1];
   logic             sticky_w [STAGES+1];

   // Whole pipeline moves together whenever the output slot is free or drains.
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   assign valid_w[0]  = in_valid;
   assign data_w[0]   = number_input;
   assign amt_w[0]    = AW'(sat_shift_amount(32'(shift_amount), WIDTH));
   assign mode_w[0]   = decode_mode(mode);
   assign sticky_w[0] = 1'b0;

   for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
      localparam int unsigned BASE_RAW = s * LPS;
      localparam int unsigned BASE     = (BASE_RAW < LVL) ? BASE_RAW : LVL;
      localparam int unsigned REM      = LVL - BASE;
      localparam int unsigned NLEV     = (s == int'(STAGES) - 1) ? REM
                                         : ((REM < LPS) ? REM : LPS);

      hub_shift_stage #(
         .WIDTH (WIDTH),
         .AW    (AW),
         .BASE  (BASE),
         .NLEV  (NLEV),
         .SAT   (s == int'(STAGES) - 1)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .adv_i    (adv),
         .valid_i  (valid_w[s]),
         .data_i   (data_w[s]),
         .amt_i    (amt_w[s]),
         .mode_i   (mode_w[s]),
         .sticky_i (sticky_w[s]),
         .valid_o  (valid_w[s+1]),
         .data_o   (data_w[s+1]),
         .amt_o    (amt_w[s+1]),
         .mode_o   (mode_w[s+1]),
         .sticky_o (sticky_w[s+1])
      );
   end

   assign out_valid     = valid_w[STAGES];
   assign number_output = data_w[STAGES];
   assign sticky        = sticky_w[STAGES];

endmodule

// File: tb/tb_hub_shift_pipe.sv
// Bench for hub_shift_pipe: three instances (STAGES = 2, 1, 5) checked against
// an arithmetic reference model.
module tb_hub_shift_pipe;

   localparam int W = 30;

   logic clk;
   logic rst;
   logic         iv   [3];
   logic         ir   [3];
   logic [W-1:0] din  [3];
   logic [8:0]   amt  [3];
   logic [1:0]   md   [3];
   logic         ov   [3];
   logic         ordy [3];
   logic [W-1:0] dout [3];
   logic         st   [3];

   int n_chk  = 0;
   int n_pass = 0;

   hub_shift_pipe #(.STAGES(2)) u_s2 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .number_input(din[0]), .shift_amount(amt[0]), .mode(md[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .number_output(dout[0]), .sticky(st[0]));

   hub_shift_pipe #(.STAGES(1)) u_s1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .number_input(din[1]), .shift_amount(amt[1]), .mode(md[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .number_output(dout[1]), .sticky(st[1]));

   hub_shift_pipe #(.STAGES(5)) u_s5 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
      .number_input(din[2]), .shift_amount(amt[2]), .mode(md[2]),
      .out_valid(ov[2]), .out_ready(ordy[2]), .number_output(dout[2]), .sticky(st[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int stg(input int d);
      case (d)
         0:       return 2;
         1:       return 1;
         default: return 5;
      endcase
   endfunction

   // Reference: {sticky, result} from plain arithmetic on the whole word.
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [8:0] a,
                                        input logic [1:0] m);
      longint unsigned wide;
      logic [W-1:0]    r;
      logic [W-1:0]    lo;
      logic            s;
      int              n;
      n = int'(a);
      if (n >= W) begin
         r = (m == 2'b10 && x[W-1]) ? {W{1'b1}} : '0;
         s = |x;
      end else if (m == 2'b00) begin
         wide = 64'(x) << n;
         r    = wide[W-1:0];
         s    = |(wide >> W);
      end else begin
         r = x >> n;
         if (m == 2'b10 && x[W-1]) r = r | ~({W{1'b1}} >> n);
         lo = (W'(1) << n) - W'(1);
         s  = |(x & lo);
      end
      return {s, r};
   endfunction

   function automatic logic [W-1:0] rword();
      logic [W-1:0] r;
      r = W'($urandom);
      if ($urandom_range(0, 3) == 0) r = r >> $urandom_range(0, 29);
      return r;
   endfunction

   function automatic logic [8:0] ramt();
      if ($urandom_range(0, 3) == 0) return 9'($urandom_range(0, 511));
      return 9'($urandom_range(0, 31));
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reset state of every instance, including in_ready right after release.
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         n_chk++; if (ov[d] !== 1'b0) $display("FAIL rst_out_valid dut%0d: got %b expected 0", d, ov[d]); else n_pass++;
         n_chk++; if (dout[d] !== '0) $display("FAIL rst_number_output dut%0d: got %h expected 0", d, dout[d]); else n_pass++;
         n_chk++; if (st[d] !== 1'b0) $display("FAIL rst_sticky dut%0d: got %b expected 0", d, st[d]); else n_pass++;
         n_chk++; if (ir[d] !== 1'b1) $display("FAIL rst_in_ready dut%0d: got %b expected 1", d, ir[d]); else n_pass++;
      end
   endtask

   // One operand into an empty pipeline: acceptance, latency, result, sticky.
   task automatic test_vec(input int d, input string nm, input logic [W-1:0] x,
                           input logic [8:0] a, input logic [1:0] m,
                           input logic [W-1:0] er, input logic es);
      int cnt;
      logic [W:0] mref;
      mref    = model(x, a, m);
      iv[d]   = 1'b1;
      din[d]  = x;
      amt[d]  = a;
      md[d]   = m;
      ordy[d] = 1'b1;
      #1;
      n_chk++; if (ir[d] !== 1'b1) $display("FAIL %s_in_ready dut%0d: got %b expected 1", nm, d, ir[d]); else n_pass++;
      tick();
      iv[d] = 1'b0;
      cnt   = 1;
      while (ov[d] !== 1'b1 && cnt < 20) begin
         tick();
         cnt++;
      end
      n_chk++; if (cnt != stg(d)) $display("FAIL %s_latency dut%0d: got %0d cycles expected %0d", nm, d, cnt, stg(d)); else n_pass++;
      n_chk++; if (dout[d] !== er) $display("FAIL %s_result dut%0d: got %h expected %h", nm, d, dout[d], er); else n_pass++;
      n_chk++; if (st[d] !== es) $display("FAIL %s_sticky dut%0d: got %b expected %b", nm, d, st[d], es); else n_pass++;
      n_chk++; if ({st[d], dout[d]} !== mref) $display("FAIL %s_model dut%0d: got %h expected %h", nm, d, {st[d], dout[d]}, mref); else n_pass++;
      tick();
   endtask

   task automatic test_directed(input int d);
      test_vec(d, "rarith4",   30'h2000_0000, 9'd4,  2'b10, 30'h3E00_0000, 1'b0);
      test_vec(d, "rlog4",     30'h0000_00FF, 9'd4,  2'b01, 30'h0000_000F, 1'b1);
      test_vec(d, "rlog0",     30'h0000_00FF, 9'd0,  2'b01, 30'h0000_00FF, 1'b0);
      test_vec(d, "rsv4",      30'h0000_00FF, 9'd4,  2'b11, 30'h0000_000F, 1'b1);
      test_vec(d, "sat_arith", 30'h2000_0001, 9'd40, 2'b10, 30'h3FFF_FFFF, 1'b1);
      test_vec(d, "sat_rlog",  30'h2000_0001, 9'd40, 2'b01, 30'h0000_0000, 1'b1);
      test_vec(d, "sat_left0", 30'h0000_0000, 9'd40, 2'b00, 30'h0000_0000, 1'b0);
      test_vec(d, "left1_ovf", 30'h2000_0001, 9'd1,  2'b00, 30'h0000_0002, 1'b1);
      test_vec(d, "left29",    30'h0000_0001, 9'd29, 2'b00, 30'h2000_0000, 1'b0);
      test_vec(d, "rlog_w",    30'h0000_0001, 9'd30, 2'b01, 30'h0000_0000, 1'b1);
      test_vec(d, "rarith29",  30'h2000_0000, 9'd29, 2'b10, 30'h3FFF_FFFF, 1'b0);
   endtask

   // Six back-to-back operands with a five-cycle output stall once results appear.
   task automatic test_back_to_back(input int d);
      logic [W-1:0] ox [6];
      logic [8:0]   oa [6];
      logic [1:0]   om [6];
      logic [W:0]   q [$];
      logic [W:0]   e;
      logic [W:0]   held;
      int sent = 0, got = 0, stall = 0, guard = 0;
      bit stalled = 1'b0;
      held = '0;
      for (int i = 0; i < 6; i++) begin
         ox[i] = rword();
         oa[i] = ramt();
         om[i] = 2'($urandom_range(0, 3));
      end
      while (got < 6 && guard < 200) begin
         iv[d] = (sent < 6);
         if (sent < 6) begin
            din[d] = ox[sent];
            amt[d] = oa[sent];
            md[d]  = om[sent];
         end
         if (!stalled && stall == 0 && ov[d] === 1'b1) stall = 5;
         ordy[d] = (stall == 0);
         #1;
         if (stall > 0) begin
            n_chk++; if (ir[d] !== 1'b0) $display("FAIL bp_in_ready dut%0d: got %b expected 0", d, ir[d]); else n_pass++;
            if (stall == 5) held = {st[d], dout[d]};
            else begin
               n_chk++; if ({st[d], dout[d]} !== held) $display("FAIL bp_hold dut%0d: got %h expected %h", d, {st[d], dout[d]}, held); else n_pass++;
            end
            stall--;
            if (stall == 0) stalled = 1'b1;
         end
         if (ov[d] === 1'b1 && ordy[d]) begin
            n_chk++;
            if (q.size() == 0) $display("FAIL bp_extra dut%0d: got %h expected no result", d, {st[d], dout[d]});
            else begin
               e = q.pop_front();
               if ({st[d], dout[d]} !== e) $display("FAIL bp_result dut%0d: got %h expected %h", d, {st[d], dout[d]}, e); else n_pass++;
            end
            got++;
         end
         if (iv[d] && ir[d] === 1'b1) begin
            q.push_back(model(din[d], amt[d], md[d]));
            sent++;
         end
         tick();
         guard++;
      end
      iv[d]   = 1'b0;
      ordy[d] = 1'b1;
      n_chk++;
      if (got != 6 || q.size() != 0 || !stalled)
         $display("FAIL bp_count dut%0d: got %0d results (%0d pending, stalled=%b) expected 6", d, got, q.size(), stalled);
      else n_pass++;
   endtask

   // Random valid/ready patterns against the scoreboard.
   task automatic test_random(input int d, input int n);
      logic [W:0] q [$];
      logic [W:0] e;
      int sent = 0, got = 0, guard = 0;
      while (got < n && guard < 2000) begin
         iv[d] = (sent < n) && ($urandom_range(0, 3) != 0);
         if (iv[d]) begin
            din[d] = rword();
            amt[d] = ramt();
            md[d]  = 2'($urandom_range(0, 3));
         end
         ordy[d] = ($urandom_range(0, 3) != 0);
         #1;
         if (ov[d] === 1'b1 && ordy[d]) begin
            n_chk++;
            if (q.size() == 0) $display("FAIL rnd_extra dut%0d: got %h expected no result", d, {st[d], dout[d]});
            else begin
               e = q.pop_front();
               if ({st[d], dout[d]} !== e) $display("FAIL rnd_result dut%0d: got %h expected %h", d, {st[d], dout[d]}, e); else n_pass++;
            end
            got++;
         end
         if (iv[d] && ir[d] === 1'b1) begin
            q.push_back(model(din[d], amt[d], md[d]));
            sent++;
         end
         tick();
         guard++;
      end
      iv[d]   = 1'b0;
      ordy[d] = 1'b1;
      n_chk++;
      if (got != n || q.size() != 0) $display("FAIL rnd_count dut%0d: got %0d results (%0d pending) expected %0d", d, got, q.size(), n);
      else n_pass++;
   endtask

   // Reset with two operands in flight: they must vanish, a fresh one must work.
   task automatic test_reset_flight(input int d);
      int stray = 0;
      ordy[d] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         iv[d]  = 1'b1;
         din[d] = rword();
         amt[d] = ramt();
         md[d]  = 2'($urandom_range(0, 3));
         tick();
      end
      iv[d] = 1'b0;
      rst   = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_chk++; if (ov[d] !== 1'b0) $display("FAIL rf_out_valid dut%0d: got %b expected 0", d, ov[d]); else n_pass++;
      n_chk++; if (dout[d] !== '0) $display("FAIL rf_number_output dut%0d: got %h expected 0", d, dout[d]); else n_pass++;
      n_chk++; if (st[d] !== 1'b0) $display("FAIL rf_sticky dut%0d: got %b expected 0", d, st[d]); else n_pass++;
      n_chk++; if (ir[d] !== 1'b1) $display("FAIL rf_in_ready dut%0d: got %b expected 1", d, ir[d]); else n_pass++;
      test_vec(d, "rf_fresh", 30'h0000_0F0F, 9'd8, 2'b01, 30'h0000_000F, 1'b1);
      for (int i = 0; i < 8; i++) begin
         if (ov[d] === 1'b1) stray++;
         tick();
      end
      n_chk++; if (stray != 0) $display("FAIL rf_stray dut%0d: got %0d stray results expected 0", d, stray); else n_pass++;
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0; din[d] = '0; amt[d] = '0; md[d] = 2'b00; ordy[d] = 1'b0;
      end
      test_reset();
      for (int d = 0; d < 3; d++) test_directed(d);
      for (int d = 0; d < 3; d++) test_back_to_back(d);
      for (int d = 0; d < 3; d++) test_random(d, 40);
      test_reset_flight(0);
      test_reset_flight(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
